// File: rtl/mua_stream_tx.sv
// mua_stream_tx: tags serial per-channel MUA samples with frame number,
// channel number, per-channel hash and threshold, and drives the result
// into the spike-detect wrapper with a fixed 2-cycle latency.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/data/last     upstream sample stream (no backpressure)
//   cfg_we/sel/addr/wdata  host write port for threshold (sel=0) / hash (sel=1) tables
//   err_clr                clears sticky framing error flags
//   mua_valid, frameNo_out, chNo_out, ch_hash_out, thr_out, mua_out
//                          tagged output beat (held while mua_valid=0)
//   err_short, err_long    sticky framing errors
module mua_stream_tx #(
    parameter int unsigned N_CH       = 160,
    parameter logic [31:0] FRAME_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [11:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        err_clr,
    output logic        mua_valid,
    output logic [31:0] frameNo_out,
    output logic [11:0] chNo_out,
    output logic [31:0] ch_hash_out,
    output logic [31:0] thr_out,
    output logic [31:0] mua_out,
    output logic        err_short,
    output logic        err_long
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 12;
    localparam int unsigned AW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    // Channel / frame counters and sticky flags
    logic [CW-1:0] ch_cnt_q,    ch_cnt_d;
    logic [DW-1:0] frame_cnt_q, frame_cnt_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q,  err_long_d;

    // Stage 1
    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_data_q,  s1_data_d;
    logic [CW-1:0] s1_ch_q,    s1_ch_d;
    logic [DW-1:0] s1_frame_q, s1_frame_d;

    // Stage 2 (outputs)
    logic          mua_valid_q, mua_valid_d;
    logic [DW-1:0] frame_out_q, frame_out_d;
    logic [CW-1:0] ch_out_q,    ch_out_d;
    logic [DW-1:0] hash_out_q,  hash_out_d;
    logic [DW-1:0] thr_out_q,   thr_out_d;
    logic [DW-1:0] mua_out_q,   mua_out_d;

    // Tables and their registered read data (not reset)
    logic [DW-1:0] thr_mem  [N_CH];
    logic [DW-1:0] hash_mem [N_CH];
    logic [DW-1:0] thr_rd_q;
    logic [DW-1:0] hash_rd_q;

    logic          cfg_hit;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          frame_end;
    logic          set_short;
    logic          set_long;

    assign cfg_hit = cfg_we && (32'(cfg_addr) < N_CH);
    assign wr_idx  = AW'(cfg_addr);
    assign rd_idx  = AW'(ch_cnt_q);

    // Table write plus synchronous read; nonblocking update gives read-first
    always_ff @(posedge clk) begin
        if (cfg_hit && !cfg_sel) thr_mem[wr_idx]  <= cfg_wdata;
        if (cfg_hit &&  cfg_sel) hash_mem[wr_idx] <= cfg_wdata;
        if (in_valid) begin
            thr_rd_q  <= thr_mem[rd_idx];
            hash_rd_q <= hash_mem[rd_idx];
        end
    end

    // Next-state logic for counters, flags and both pipeline stages
    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;
        s1_valid_d  = in_valid;
        s1_data_d   = s1_data_q;
        s1_ch_d     = s1_ch_q;
        s1_frame_d  = s1_frame_q;
        mua_valid_d = s1_valid_q;
        frame_out_d = frame_out_q;
        ch_out_d    = ch_out_q;
        hash_out_d  = hash_out_q;
        thr_out_d   = thr_out_q;
        mua_out_d   = mua_out_q;

        // A frame ends on in_last or when the last channel is reached, whichever first
        frame_end = in_last || (ch_cnt_q == LAST_CH);
        set_short = in_valid &&  in_last && (ch_cnt_q < LAST_CH);
        set_long  = in_valid && !in_last && (ch_cnt_q == LAST_CH);

        if (in_valid) begin
            if (frame_end) begin
                ch_cnt_d    = '0;
                frame_cnt_d = frame_cnt_q + 32'd1;
            end else begin
                ch_cnt_d    = ch_cnt_q + 12'd1;
            end
            s1_data_d  = in_data;
            s1_ch_d    = ch_cnt_q;
            s1_frame_d = frame_cnt_q;
        end

        // Set beats clear when both happen in the same cycle
        err_short_d = set_short || (err_short_q && !err_clr);
        err_long_d  = set_long  || (err_long_q  && !err_clr);

        if (s1_valid_q) begin
            frame_out_d = s1_frame_q;
            ch_out_d    = s1_ch_q;
            hash_out_d  = hash_rd_q;
            thr_out_d   = thr_rd_q;
            mua_out_d   = s1_data_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_q    <= '0;
            frame_cnt_q <= FRAME_INIT;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_ch_q     <= '0;
            s1_frame_q  <= '0;
            mua_valid_q <= 1'b0;
            frame_out_q <= '0;
            ch_out_q    <= '0;
            hash_out_q  <= '0;
            thr_out_q   <= '0;
            mua_out_q   <= '0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_ch_q     <= s1_ch_d;
            s1_frame_q  <= s1_frame_d;
            mua_valid_q <= mua_valid_d;
            frame_out_q <= frame_out_d;
            ch_out_q    <= ch_out_d;
            hash_out_q  <= hash_out_d;
            thr_out_q   <= thr_out_d;
            mua_out_q   <= mua_out_d;
        end
    end

    assign mua_valid   = mua_valid_q;
    assign frameNo_out = frame_out_q;
    assign chNo_out    = ch_out_q;
    assign ch_hash_out = hash_out_q;
    assign thr_out     = thr_out_q;
    assign mua_out     = mua_out_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;

endmodule

// File: doc/mua_stream_tx.md
Name: mua_stream_tx

Overview:
- Transmit side of the mua stream consumed by the spike-detect wrapper.
- Accepts serial per-channel MUA samples from the upstream filter bank, one beat per channel, frame delimited by in_last.
- Tags each beat with frame number, channel number, per-channel hash and per-channel threshold, then drives the mua_valid/frameNo/chNo/ch_hash/thr/mua bus into the detector wrapper.
- Threshold and hash tables are host-writable through a simple config port.

Parameters:
N_CH, 160, channels per frame; table depth; legal range 2..4096
FRAME_INIT, 0, frame number loaded at reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  sample beat valid (no backpressure)
in_data  in  32  filtered MUA sample
in_last  in  1  beat is last channel of frame
cfg_we  in  1  table write strobe
cfg_sel  in  1  0 = threshold table, 1 = hash table
cfg_addr  in  12  channel index to write
cfg_wdata  in  32  table write data
err_clr  in  1  clears sticky error flags
mua_valid  out  1  output beat valid
frameNo_out  out  32  frame number of beat
chNo_out  out  12  channel number of beat
ch_hash_out  out  32  hash table entry for chNo_out
thr_out  out  32  threshold table entry for chNo_out
mua_out  out  32  sample, passed through unmodified
err_short  out  1  sticky: in_last arrived before channel N_CH-1
err_long  out  1  sticky: channel N_CH-1 reached without in_last

Behaviour:
- Reset (async assert, sync release), forced on every register except table contents:
  - mua_valid=0; all data outputs 0.
  - ch_cnt=0, frame_cnt=FRAME_INIT.
  - err_short=0, err_long=0.
  - Table contents are undefined until written; reset does not clear the RAM.
- Channel/frame counters, on every in_valid beat:
  - If in_last=1 or ch_cnt==N_CH-1: ch_cnt <= 0 and frame_cnt <= frame_cnt+1, mod 2^32 (0xFFFFFFFF wraps to 0).
  - Otherwise: ch_cnt <= ch_cnt+1.
  - A beat with in_valid=0 changes nothing.
- Error flags:
  - in_last=1 with ch_cnt<N_CH-1: set err_short; the frame ends at that beat.
  - ch_cnt==N_CH-1 with in_last=0: set err_long; the frame is forcibly ended and the next beat is channel 0 of a new frame.
  - err_clr clears both flags. If a set condition and err_clr occur in the same cycle, set wins.
  - Flags never suppress output beats.
- Pipeline, fixed latency 2 cycles from in_valid to mua_valid:
  - Stage 1 registers valid, sample, ch_cnt and frame_cnt, and issues a synchronous read of both tables at ch_cnt.
  - Stage 2 registers the table read data together with the stage-1 fields onto the outputs.
  - One output beat per input beat, order preserved. Back-to-back input produces back-to-back output.
- Output hold: outputs hold their last value when mua_valid=0. Downstream must qualify with mua_valid.
- Table port:
  - Single write port, selected by cfg_sel.
  - Write and stream read to the same address in the same cycle: the read returns the old value (read-first). The new value is seen from the next read onward.
  - cfg_addr >= N_CH: the write is ignored.
  - Writes are allowed at any time, including mid-frame.
- Reset mid-frame: in-flight pipeline beats are dropped (mua_valid=0 immediately on assertion). The first beat after release is channel 0, frame FRAME_INIT.
- Widths: chNo_out = ch_cnt zero-extended to 12 bits. No arithmetic is applied to data.

Test Plan:
1. Write thr[ch]=0x100+ch and hash[ch]=0xA000+ch for all ch; stream 2 full frames of N_CH beats, in_data=ch, in_last on ch 159 -> 320 output beats, each exactly 2 cycles after its input. Frame 0 then 1; chNo 0..159; thr/hash match the table; no error flags.
2. Short frame: in_last on ch 9 -> err_short=1, next beat is frame+1 ch 0. Assert err_clr -> err_short=0 the next cycle.
3. Long frame: hold in_last=0 across 162 beats -> err_long=1, beat 160 is ch 0 of frame+1, beat 161 is ch 1.
4. Same-cycle write thr[5]=0xDEAD while ch 5 is being read -> that beat carries the old value; ch 5 of the next frame carries 0xDEAD. A write with cfg_addr=200 changes nothing.
5. Set FRAME_INIT=0xFFFFFFFE and run 3 frames -> frameNo_out sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
6. Assert rst_n low at ch 50 with beats in flight -> mua_valid=0 the same cycle, no stale beat after release, the next frame starts at ch 0 with frameNo=FRAME_INIT.
